serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/serial_adder_fa_bit.sv | 28 ++
 rtl/serial_adder.sv | 121 ++++++++++++
 tb/tb_serial_adder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and sizing helpers for the bit-serial adder
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bit counter only has to reach WIDTH-1; keep at least one bit.
   function automatic int cnt_width(input int w);
      return (w > 2) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_fa_bit.sv
// rtl/serial_adder_fa_bit.sv - full-adder cell built from two half-adder stages
module ha_bit (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule

module fa_bit (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic cout
);
   logic s0;
   logic c0;
   logic c1;

   ha_bit u_ha0 (.x(x),  .y(y),   .s(s0), .c(c0));
   ha_bit u_ha1 (.x(s0), .y(cin), .s(s),  .c(c1));

   // The two half-adder carries can never both be set, so OR gives the majority.
   assign cout = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial adder; SERIAL_ADDER_SUB_EN adds a subtract port
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic             last_bit;
   logic             fa_s;
   logic             fa_c;
   logic [WIDTH-1:0] b_load;
   logic             carry_init;

`ifdef SERIAL_ADDER_SUB_EN
   // a - b == a + ~b + 1; the +1 rides in through the initial carry.
   assign b_load     = sub ? ~b : b;
   assign carry_init = sub;
`else
   assign b_load     = b;
   assign carry_init = 1'b0;
`endif

   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   fa_bit u_fa (
      .x   (a_sr[0]),
      .y   (b_sr[0]),
      .cin (carry_q),
      .s   (fa_s),
      .cout(fa_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = ADD;
         end
         ADD: begin
            if (last_bit) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr      <= '0;
         b_sr      <= '0;
         sum_sr    <= '0;
         carry_q   <= 1'b0;
         cnt_q     <= '0;
         sum       <= '0;
         carry_out <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_sr    <= a;
                  b_sr    <= b_load;
                  carry_q <= carry_init;
                  cnt_q   <= '0;
               end
            end
            ADD: begin
               a_sr    <= a_sr >> 1;
               b_sr    <= b_sr >> 1;
               sum_sr  <= {fa_s, sum_sr[WIDTH-1:1]};
               carry_q <= fa_c;
               // Result registers are only written on the final bit, so they hold between operations.
               if (last_bit) begin
                  sum       <= {fa_s, sum_sr[WIDTH-1:1]};
                  carry_out <= fa_c;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder (WIDTH=8)
module tb_serial_adder;

   localparam int W = 8;

   typedef struct {
      logic [8:0] tot;
      int         due;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         carry_out;

   exp_t         q[$];
   int           cyc = 0;
   int           checks = 0;
   int           errors = 0;
   logic         prev_valid = 1'b0;
   logic         prev_ready = 1'b0;
   logic [W-1:0] held_sum;
   logic         held_c;

   serial_adder #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
`ifdef SERIAL_ADDER_SUB_EN
      .sub      (sub),
`endif
      .a        (a),
      .b        (b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .carry_out(carry_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Monitor: samples at the falling edge, well away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         if (out_valid && !prev_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               chk("latency", cyc, q[0].due);
            end
            held_sum = sum;
            held_c   = carry_out;
         end
         if (out_valid && prev_valid && !prev_ready) begin
            chk("hold_sum", sum, held_sum);
            chk("hold_carry", carry_out, held_c);
            chk("in_ready_busy", in_ready, 0);
         end
         if (out_valid && out_ready && q.size() != 0) begin
            chk("sum", sum, q[0].tot[7:0]);
            chk("carry_out", carry_out, q[0].tot[8]);
            void'(q.pop_front());
         end
         prev_valid = out_valid;
         prev_ready = out_ready;
      end
   end

   // Called at posedge+1; returns at posedge+1 of the accept edge.
   task automatic send(input logic [7:0] x, input logic [7:0] y, input logic s,
                       input logic keep, output int t);
      int         n;
      exp_t       e;
      logic [7:0] yy;
      in_valid = 1'b1;
      a = x;
      b = y;
      sub = s;
      t = -1;
      for (n = 0; n < 100; n++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      if (!in_ready) begin
         chk("accept_timeout", in_ready, 1);
      end else begin
         t = cyc + 1;
         yy = s ? ~y : y;
         e.tot = {1'b0, x} + {1'b0, yy} + {8'd0, s};
         e.due = t + W;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      for (n = 0; n < 200; n++) begin
         @(negedge clk);
         if (q.size() == 0 && !out_valid) break;
      end
      if (q.size() != 0) chk("drain_timeout", q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t1;
      int t2;
      int n;
      rst = 1'b1;
      in_valid = 1'b0;
      sub = 1'b0;
      a = '0;
      b = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_carry", carry_out, 0);
      @(posedge clk);
      #1;

      send(8'h0F, 8'h01, 1'b0, 1'b0, t1);
      drain();
      send(8'hFF, 8'h01, 1'b0, 1'b0, t1);
      drain();
      send(8'hAA, 8'h55, 1'b0, 1'b0, t1);
      drain();

      // Backpressure with an ignored in_valid while the result is parked.
      out_ready = 1'b0;
      send(8'h12, 8'h34, 1'b0, 1'b0, t1);
      for (n = 0; n < 50; n++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      if (!out_valid) chk("out_valid_timeout", out_valid, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a = 8'h77;
      b = 8'h11;
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("release_in_ready", in_ready, 1);
      chk("release_out_valid", out_valid, 0);
      drain();

      // Back-to-back with in_valid held high.
      send(8'h03, 8'h04, 1'b0, 1'b1, t1);
      send(8'h80, 8'h80, 1'b0, 1'b0, t2);
      chk("b2b_interval", t2 - t1, W + 2);
      drain();

      // Reset during the 4th ADD cycle.
      send(8'h55, 8'h22, 1'b0, 1'b0, t1);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      @(negedge clk);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_valid", out_valid, 0);
      @(posedge clk);
      #1;
      send(8'h01, 8'h01, 1'b0, 1'b0, t1);
      drain();

`ifdef SERIAL_ADDER_SUB_EN
      send(8'h05, 8'h07, 1'b1, 1'b0, t1);
      drain();
      send(8'h07, 8'h05, 1'b1, 1'b0, t1);
      drain();
`endif

      repeat (20) @(negedge clk);
      chk("scoreboard_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
